run_scan_ctrl: RTL and testbench
================================

# run_scan_ctrl

Front-end controller for the serial run-pattern detector: arbitrates between two parallel-word requesters, clears the detector, and shifts the granted word into it MSB-first, one bit per clock. It counts the detector's match pulses over the word and returns the count to the requester that was granted. It sits between the word producers and a single shared detector instance, which has one serial input, one Mealy output and an active-low asynchronous reset.

## Interface
- `WIDTH`, 8 — bits per word shifted into the detector.
- `CNT_W`, 4 — result width; must satisfy 2^CNT_W > WIDTH.
- `clk` in 1 — single clock, rising edge.
- `RESET` in 1 — asynchronous, active-high reset for the whole block.
- `req_a`, `req_b` in 1 — request; held high with data stable until the matching `gnt_*` pulse.
- `data_a`, `data_b` in WIDTH — word to scan.
- `gnt_a`, `gnt_b` out 1 — one-cycle pulse; the word is captured in this cycle.
- `done_a`, `done_b` out 1 — one-cycle pulse; `result` is valid in this cycle.
- `result` out CNT_W — match count of the last completed scan; held until the next `DONE`.
- `busy` out 1 — high in every state except `IDLE`.
- `det_nreset` out 1 — registered active-low reset to the detector.
- `det_in` out 1 — registered serial bit to the detector.
- `det_out` in 1 — detector Mealy output; combinational from `det_in` and detector state.

## Operation
- **States:** `IDLE`, `CLEAR`, `SHIFT`, `DONE`.
- **`IDLE`:**
  - If any request is high, grant one requester: pulse its `gnt_*`, load its data into a WIDTH-bit shift register, record the grant id, clear the match counter, go to `CLEAR`.
  - If no request is high, stay in `IDLE`.
- **Arbitration:**
  - Single request: grant it.
  - Both requests high: grant the requester not granted last (round-robin).
  - The last-grant pointer resets to B, so A wins the first tie.
- **`CLEAR`:** one cycle, `det_nreset`=0, `det_in`=0. Go to `SHIFT`.
- **`SHIFT`:**
  - Lasts WIDTH cycles, with `det_nreset`=1.
  - `det_in` = shift register MSB; shift left each cycle.
  - At each of these WIDTH clock edges, add `det_out` to the counter.
  - The bit counter runs 0..WIDTH-1; on the last bit, go to `DONE`.
- **`DONE`:**
  - One cycle; `result` = counter.
  - Pulse `done_*` for the recorded grant id only.
  - Return to `IDLE`. No new grant is issued in this cycle.
- **Arithmetic:** the counter is CNT_W bits, maximum value WIDTH, with no wrap.
- **Requests during a scan:** ignored, no grant while `busy`. A request that drops before its grant is simply not served.
- **Reset (asynchronous, including mid-scan):**
  - State → `IDLE`, pointer → B.
  - `gnt_*`=0, `done_*`=0, `result`=0, `busy`=0, `det_in`=0, `det_nreset`=0.
  - The abandoned scan produces no `done`.
- **First clock edge after `RESET` falls:** `det_nreset`→1.

## Timing
- Request seen in `IDLE` at cycle t:
  - `gnt` in t.
  - `CLEAR` in t+1.
  - Bits on `det_in` in t+2..t+WIDTH+1, MSB first.
  - `done`/`result` in t+WIDTH+2.
- Earliest next grant: t+WIDTH+3. Throughput is one word per WIDTH+3 cycles.
- `det_in`, `det_nreset`, `gnt_*`, `done_*`, `result` and `busy` are all registered or decoded from registered state; no combinational path from `req_*`.
- `det_out` is sampled only in `SHIFT` cycles; its value during `CLEAR`, `DONE` and `IDLE` is ignored.

## Test plan
- **Single scan.** Reset, then `req_a`=1, `data_a`=8'hF0; bench detector model drives `det_out`=1 on SHIFT cycles 4–7.
  - `gnt_a` at t, `det_in` sequence 1,1,1,1,0,0,0,0 on t+2..t+9.
  - `det_nreset`=0 only at t+1.
  - `done_a` at t+10 with `result`=4; `done_b` stays 0.
- **Tie and round-robin.** `req_a`=`req_b`=1 held continuously.
  - Grants go A, B, A, B, 11 cycles apart.
  - Each `done` goes to the matching side.
- **Count boundaries.**
  - `det_out` held 1 for a whole scan → `result`=8.
  - `det_out` held 0 → `result`=0.
  - `result` holds its value through the following `IDLE` cycles.
- **Request during a scan.** `req_b` rises mid-`SHIFT` of an A scan.
  - No `gnt_b` before `DONE`.
  - `gnt_b` in the `IDLE` cycle right after `DONE`.
- **Reset mid-scan.** `RESET` pulses during SHIFT bit 3.
  - All outputs take reset values at once and `det_nreset`=0.
  - No `done` is emitted.
  - The next A/B tie grants A.
- **Unserved request.** `req_b` pulses for 2 cycles while `busy`, then drops.
  - It is never granted.
  - `busy` falls after `DONE` and the block stays in `IDLE`.

Source files
------------

// File: rtl/run_scan_ctrl.sv
// -----------------------------------------------------------------------------
// run_scan_ctrl
//
// Front-end for a shared serial run-pattern detector. It arbitrates between two
// word requesters (round-robin on ties), clears the detector for one cycle,
// shifts the granted word into it MSB-first, counts the detector's match pulses,
// and reports the count back to the side that was granted.
//
// Ports
//   clk            rising-edge clock
//   RESET          asynchronous, active-high reset of the whole block
//   req_a/req_b    requests; held high with data stable until the gnt pulse
//   data_a/data_b  WIDTH-bit words to scan
//   gnt_a/gnt_b    one-cycle grant pulse (registered)
//   done_a/done_b  one-cycle completion pulse; result valid in this cycle
//   result         match count of the last completed scan, held until next done
//   busy           high whenever the FSM is not in IDLE
//   det_nreset     registered active-low reset to the detector
//   det_in         registered serial bit to the detector
//   det_out        detector Mealy output, sampled only while shifting
// -----------------------------------------------------------------------------
module run_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done_a,
    output logic             done_b,
    output logic [CNT_W-1:0] result,
    output logic             busy,
    output logic             det_nreset,
    output logic             det_in,
    input  logic             det_out
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    localparam int               BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    state_t           stateReg;
    state_t           stateNext;
    logic [WIDTH-1:0] shiftReg;
    logic [BW-1:0]    bitCnt;
    logic [CNT_W-1:0] matchCnt;
    logic [CNT_W-1:0] cntPlus;
    logic             grantB;
    logic             lastGntB;
    logic             grantWindow;
    logic             anyReq;
    logic             pickB;
    logic             lastBit;

    // Grants are registered so no output depends combinationally on req_*.
    // The decision is taken at the edge that opens the gnt cycle: either in
    // IDLE while no grant is already showing, or at the edge leaving DONE so
    // that back-to-back words keep a WIDTH+3 cycle cadence. The gnt pulse
    // itself is therefore always seen in an IDLE cycle.
    assign anyReq      = req_a | req_b;
    assign grantWindow = ((stateReg == IDLE) && !(gnt_a || gnt_b)) || (stateReg == DONE);
    assign pickB       = req_b && (!req_a || !lastGntB);
    assign lastBit     = (stateReg == SHIFT) && (bitCnt == LAST_BIT);
    // Saturating add; the count cannot legitimately exceed WIDTH.
    assign cntPlus     = (matchCnt == CNT_MAX) ? matchCnt : matchCnt + CNT_W'(det_out);

    // State register
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (gnt_a || gnt_b) stateNext = CLEAR;
            CLEAR:   stateNext = SHIFT;
            SHIFT:   if (lastBit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        busy   = (stateReg != IDLE);
        done_a = (stateReg == DONE) && !grantB;
        done_b = (stateReg == DONE) && grantB;
    end

    // Registered datapath and registered outputs
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            lastGntB   <= 1'b1;
            grantB     <= 1'b0;
            shiftReg   <= '0;
            bitCnt     <= '0;
            matchCnt   <= '0;
            result     <= '0;
            det_in     <= 1'b0;
            det_nreset <= 1'b0;
        end else begin
            gnt_a      <= grantWindow && anyReq && !pickB;
            gnt_b      <= grantWindow && anyReq && pickB;
            det_nreset <= (stateNext != CLEAR);

            // Word, side and counter are captured together with the grant
            // decision, while the request is guaranteed valid.
            if (grantWindow && anyReq) begin
                lastGntB <= pickB;
                grantB   <= pickB;
                shiftReg <= pickB ? data_b : data_a;
                matchCnt <= '0;
            end

            case (stateReg)
                CLEAR: begin
                    det_in   <= shiftReg[WIDTH-1];
                    shiftReg <= shiftReg << 1;
                    bitCnt   <= '0;
                end
                SHIFT: begin
                    matchCnt <= cntPlus;
                    if (lastBit) begin
                        result <= cntPlus;
                        det_in <= 1'b0;
                    end else begin
                        det_in   <= shiftReg[WIDTH-1];
                        shiftReg <= shiftReg << 1;
                        bitCnt   <= bitCnt + BW'(1);
                    end
                end
                default: begin
                    det_in <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_scan_ctrl.sv
module tb_run_scan_ctrl;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic [7:0] data_b = 8'h00;
    logic       det_out = 1'b0;
    logic       gnt_a, gnt_b, done_a, done_b, busy, det_nreset, det_in;
    logic [3:0] result;

    run_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .RESET(RESET),
        .req_a(req_a), .req_b(req_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .done_a(done_a), .done_b(done_b),
        .result(result), .busy(busy),
        .det_nreset(det_nreset), .det_in(det_in),
        .det_out(det_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit sideB;
        int cnt;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {24'h0, gnt_a, gnt_b, done_a, done_b, busy, det_in, det_nreset, 1'b0}, 32'h0);
        check({tag, "_result"}, {28'h0, result}, 32'h0);
    endtask

    // Ticks until a grant shows (at most maxTicks), then checks its side.
    task automatic wait_gnt(input int maxTicks, input bit expB);
        int n = 0;
        while (!(gnt_a || gnt_b) && n < maxTicks) begin
            tick;
            n++;
        end
        check("gnt_seen", {31'h0, gnt_a | gnt_b}, 32'h1);
        check("gnt_side", {30'h0, gnt_a, gnt_b}, expB ? 32'h1 : 32'h2);
        $display("grant to %s at %0t", expB ? "B" : "A", $time);
    endtask

    // Called in the gnt cycle; walks CLEAR, WIDTH SHIFT cycles and DONE.
    // det_out is forced high outside SHIFT to show it is ignored there.
    task automatic do_scan(input bit sideB, input logic [7:0] data, input logic [7:0] mask,
                           input bit dropReq, input int bOn, input int bOff);
        exp_t e;
        sb.push_back('{sideB, $countones(mask)});
        det_out = 1'b1;
        if (dropReq) begin
            if (sideB) req_b = 1'b0;
            else       req_a = 1'b0;
        end
        tick;
        check("clear_nreset", {31'h0, det_nreset}, 32'h0);
        check("clear_busy", {31'h0, busy}, 32'h1);
        check("clear_det_in", {31'h0, det_in}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i == bOn)  req_b = 1'b1;
            if (i == bOff) req_b = 1'b0;
            det_out = mask[7-i];
            check($sformatf("shift_det_in[%0d]", i), {31'h0, det_in}, {31'h0, data[7-i]});
            check($sformatf("shift_nreset[%0d]", i), {31'h0, det_nreset}, 32'h1);
            check($sformatf("shift_quiet[%0d]", i), {28'h0, gnt_a, gnt_b, done_a, done_b}, 32'h0);
        end
        tick;
        det_out = 1'b1;
        e = sb.pop_front();
        check("done_a", {31'h0, done_a}, {31'h0, !e.sideB});
        check("done_b", {31'h0, done_b}, {31'h0, e.sideB});
        check("done_busy", {31'h0, busy}, 32'h1);
        check("result", {28'h0, result}, e.cnt);
        $display("scan %s data=%02h mask=%02h result=%0d expected=%0d", sideB ? "B" : "A",
                 data, mask, result, e.cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check_reset_vals("reset_vals");
        tick;
        RESET = 1'b0;
        check("nreset_before_edge", {31'h0, det_nreset}, 32'h0);
        tick;
        check("nreset_after_edge", {31'h0, det_nreset}, 32'h1);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Single scan: F0, detector fires on SHIFT cycles 4..7
        req_a = 1'b1; data_a = 8'hF0;
        wait_gnt(4, 1'b0);
        do_scan(1'b0, 8'hF0, 8'h0F, 1'b1, -1, -1);

        // Count boundaries and result hold
        tick;
        req_a = 1'b1; data_a = 8'h5A;
        wait_gnt(4, 1'b0);
        do_scan(1'b0, 8'h5A, 8'hFF, 1'b1, -1, -1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("result_hold[%0d]", i), {28'h0, result}, 32'h8);
            check($sformatf("hold_busy[%0d]", i), {31'h0, busy}, 32'h0);
        end
        req_b = 1'b1; data_b = 8'h3C;
        wait_gnt(4, 1'b1);
        do_scan(1'b1, 8'h3C, 8'h00, 1'b1, -1, -1);

        // Request during a scan: B rises mid-SHIFT of an A scan
        tick;
        req_a = 1'b1; data_a = 8'hA5; data_b = 8'hC3;
        wait_gnt(4, 1'b0);
        do_scan(1'b0, 8'hA5, 8'h81, 1'b1, 3, -1);
        tick;
        wait_gnt(0, 1'b1);
        do_scan(1'b1, 8'hC3, 8'h18, 1'b1, -1, -1);

        // Unserved request: B high for shift cycles 1..2 only
        tick;
        req_a = 1'b1; data_a = 8'h96;
        wait_gnt(4, 1'b0);
        do_scan(1'b0, 8'h96, 8'h24, 1'b1, 1, 3);
        for (int i = 0; i < 6; i++) begin
            tick;
            check($sformatf("unserved_gnt[%0d]", i), {30'h0, gnt_a, gnt_b}, 32'h0);
            check($sformatf("unserved_busy[%0d]", i), {31'h0, busy}, 32'h0);
        end

        // Reset mid-scan at SHIFT bit 3
        req_a = 1'b1; data_a = 8'hFF;
        wait_gnt(4, 1'b0);
        req_a = 1'b0;
        det_out = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        #2;
        RESET = 1'b1;
        #1;
        check_reset_vals("midscan_reset");
        req_a = 1'b1; req_b = 1'b1;
        data_a = 8'hC5; data_b = 8'h3A;
        tick;
        check_reset_vals("held_reset");
        RESET = 1'b0;
        begin
            int n = 0;
            while (!(gnt_a || gnt_b) && n < 4) begin
                check($sformatf("no_done_after_reset[%0d]", n), {30'h0, done_a, done_b}, 32'h0);
                tick;
                n++;
            end
        end

        // Tie held continuously: A, B, A, B, 11 cycles apart
        wait_gnt(0, 1'b0);
        do_scan(1'b0, 8'hC5, 8'h01, 1'b0, -1, -1);
        tick;
        wait_gnt(0, 1'b1);
        do_scan(1'b1, 8'h3A, 8'h80, 1'b0, -1, -1);
        tick;
        wait_gnt(0, 1'b0);
        do_scan(1'b0, 8'hC5, 8'h3F, 1'b0, -1, -1);
        tick;
        wait_gnt(0, 1'b1);
        req_a = 1'b0;
        do_scan(1'b1, 8'h3A, 8'hE7, 1'b1, -1, -1);
        tick;
        check("final_idle", {29'h0, busy, gnt_a, gnt_b}, 32'h0);
        check("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
